// File: rtl/tone_pkg.sv
// Shared definitions for the polyphonic tone synthesiser:
// note frequency table, half-period helper and voice state type.
package tone_pkg;

    localparam int SEMI_MAX = 11;

    // C3..B3 in millihertz
    localparam longint F_MHZ [0:11] = '{
        130813, 138591, 146832, 155563,
        164814, 174614, 184997, 195998,
        207652, 220000, 233082, 246942
    };

    typedef enum logic {
        V_IDLE,
        V_PLAY
    } voice_st_t;

    function automatic longint half_period(
        input longint clk_hz,
        input int     semi,
        input int     oct
    );
        longint h;
        if (semi < 0 || semi > SEMI_MAX) begin
            return 0;
        end
        h = (clk_hz * 1000) / (2 * F_MHZ[semi]);
        return h >> oct;
    endfunction

endpackage

// File: rtl/tone_synth_voice.sv
// One square-wave voice: IDLE/PLAY state, half-period counter
// and output phase.
module tone_voice
    import tone_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pause_i,
    input  logic             load_i,
    input  logic             off_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             phase_o,
    output logic             active_o
);

    voice_st_t        state_q, state_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= V_IDLE;
            half_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = V_PLAY;
        end else if (off_i) begin
            state_d = V_IDLE;
        end
    end

    // A load takes priority over a wrap landing on the same cycle.
    always_comb begin
        half_d  = half_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load_i) begin
            half_d  = half_i;
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (off_i || state_q == V_IDLE) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (!pause_i) begin
            if (cnt_q == half_q - CNT_W'(1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        active_o = (state_q == V_PLAY);
        phase_o  = phase_q;
    end

endmodule

// File: rtl/tone_synth.sv
// Polyphonic square-wave buzzer driver: command decode, voice
// array and one-bit PWM/OR mixer.
module tone_synth
    import tone_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int N_VOICES = 4,
    parameter int OCT_W    = 2,
    parameter int CNT_W    = 20,
    parameter int MIX_MODE = 0,
    localparam int VW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pause_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [VW-1:0]       cmd_voice_i,
    input  logic                cmd_on_i,
    input  logic [3:0]          cmd_semi_i,
    input  logic [OCT_W-1:0]    cmd_oct_i,
    output logic                cmd_err_o,
    output logic [N_VOICES-1:0] active_o,
    output logic                speaker_o,
    output logic                sel_o
);

    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              sel_q, sel_d;
    logic              spk_q, spk_d;
    logic [VW-1:0]     pwm_q, pwm_d;

    logic              accept, good;
    logic              bad_voice, bad_semi;
    logic [CNT_W-1:0]  half0 [16];
    logic [CNT_W-1:0]  half_sel;

    logic [N_VOICES-1:0] load, off, phase, active;

    // Base half-periods fixed at elaboration; 12..15 read as zero.
    for (genvar s = 0; s < 16; s++) begin : g_tab
        localparam logic [CNT_W-1:0] H =
            CNT_W'(half_period(longint'(CLK_HZ), s, 0));
        assign half0[s] = H;
    end

    assign accept    = cmd_valid_i & ready_q;
    assign bad_voice = int'(cmd_voice_i) >= N_VOICES;
    assign bad_semi  = cmd_on_i && (cmd_semi_i > 4'(SEMI_MAX));
    assign good      = accept & ~bad_voice & ~bad_semi;
    assign half_sel  = half0[cmd_semi_i] >> cmd_oct_i;

    for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
        assign load[v] = good && cmd_on_i
                         && int'(cmd_voice_i) == v;
        assign off[v]  = good && !cmd_on_i
                         && int'(cmd_voice_i) == v;

        tone_voice #(.CNT_W(CNT_W)) u_voice (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .pause_i  (pause_i),
            .load_i   (load[v]),
            .off_i    (off[v]),
            .half_i   (half_sel),
            .phase_o  (phase[v]),
            .active_o (active[v])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            sel_q   <= 1'b0;
            spk_q   <= 1'b0;
            pwm_q   <= '0;
        end else begin
            ready_q <= ready_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            spk_q   <= spk_d;
            pwm_q   <= pwm_d;
        end
    end

    always_comb begin
        ready_d = ~accept;
        err_d   = accept & (bad_voice | bad_semi);
        sel_d   = |active;
        pwm_d   = pwm_q;
        spk_d   = spk_q;
        if (!pause_i) begin
            if (pwm_q == VW'(N_VOICES - 1)) begin
                pwm_d = '0;
            end else begin
                pwm_d = pwm_q + VW'(1);
            end
            if (MIX_MODE != 0) begin
                spk_d = |phase;
            end else begin
                spk_d = int'(pwm_q) < $countones(phase);
            end
        end
    end

    assign cmd_ready_o = ready_q;
    assign cmd_err_o   = err_q;
    assign active_o    = active;
    assign speaker_o   = spk_q;
    assign sel_o       = sel_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench: a 4-voice PWM instance and a 3-voice OR instance
// share one command bus; CLK_HZ lowered to keep periods short.
module tb_tone_synth;

    localparam int CLK_HZ = 1_000_000;
    // half periods at 1 MHz: A3=2272, A3 oct1=1136, C3=3822, B3 oct3=253

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic       valid = 1'b0;
    logic [1:0] voice = '0;
    logic       on = 1'b0;
    logic [3:0] semi = '0;
    logic [1:0] oct = '0;

    logic       rdy_m, err_m, spk_m, sel_m;
    logic [3:0] act_m;
    logic       rdy_o, err_o, spk_o, sel_o;
    logic [2:0] act_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tone_synth #(
        .CLK_HZ(CLK_HZ), .N_VOICES(4), .OCT_W(2),
        .CNT_W(20), .MIX_MODE(0)
    ) u_mix (
        .clk_i(clk), .rst_i(rst), .pause_i(pause),
        .cmd_valid_i(valid), .cmd_ready_o(rdy_m),
        .cmd_voice_i(voice), .cmd_on_i(on),
        .cmd_semi_i(semi), .cmd_oct_i(oct),
        .cmd_err_o(err_m), .active_o(act_m),
        .speaker_o(spk_m), .sel_o(sel_m)
    );

    tone_synth #(
        .CLK_HZ(CLK_HZ), .N_VOICES(3), .OCT_W(2),
        .CNT_W(20), .MIX_MODE(1)
    ) u_or (
        .clk_i(clk), .rst_i(rst), .pause_i(pause),
        .cmd_valid_i(valid), .cmd_ready_o(rdy_o),
        .cmd_voice_i(voice), .cmd_on_i(on),
        .cmd_semi_i(semi), .cmd_oct_i(oct),
        .cmd_err_o(err_o), .active_o(act_o),
        .speaker_o(spk_o), .sel_o(sel_o)
    );

    typedef struct {
        logic [1:0] v;
        logic       on;
        logic [3:0] s;
        logic [1:0] o;
        logic       em;
        logic       eo;
        logic [3:0] am;
        logic [2:0] ao;
    } vec_t;

    vec_t tab [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] v, input logic o_n,
                        input logic [3:0] s, input logic [1:0] o);
        voice = v;
        on    = o_n;
        semi  = s;
        oct   = o;
        valid = 1'b1;
        for (int i = 0; i < 4 && !rdy_m; i++) tick();
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_spk(input bit use_or, input logic lvl,
                            input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (((use_or ? spk_o : spk_m) != lvl) && n < max);
    endtask

    task automatic ones(input int len, output int nm, output int no);
        nm = 0;
        no = 0;
        for (int i = 0; i < len; i++) begin
            tick();
            nm += int'(spk_m);
            no += int'(spk_o);
        end
    endtask

    initial begin
        int n, nm, no, r0, r1, r2, e, acc, noise;

        tab[0] = '{2'd0, 1'b1, 4'd9,  2'd0, 1'b0, 1'b0, 4'b0001, 3'b001};
        tab[1] = '{2'd1, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0, 4'b0001, 3'b001};
        tab[2] = '{2'd2, 1'b1, 4'd12, 2'd0, 1'b1, 1'b1, 4'b0001, 3'b001};
        tab[3] = '{2'd3, 1'b1, 4'd0,  2'd0, 1'b0, 1'b1, 4'b1001, 3'b001};
        tab[4] = '{2'd3, 1'b0, 4'd0,  2'd0, 1'b0, 1'b1, 4'b0001, 3'b001};
        tab[5] = '{2'd1, 1'b1, 4'd15, 2'd0, 1'b1, 1'b1, 4'b0001, 3'b001};
        tab[6] = '{2'd1, 1'b0, 4'd15, 2'd0, 1'b0, 1'b0, 4'b0001, 3'b001};
        tab[7] = '{2'd0, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0, 4'b0000, 3'b000};

        repeat (3) tick();
        chk("rst_ready", int'(rdy_m), 1);
        chk("rst_err", int'(err_m | err_o), 0);
        chk("rst_act_m", int'(act_m), 0);
        chk("rst_act_o", int'(act_o), 0);
        chk("rst_spk", int'(spk_m | spk_o), 0);
        chk("rst_sel", int'(sel_m | sel_o), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            send(tab[i].v, tab[i].on, tab[i].s, tab[i].o);
            chk($sformatf("v%0d_err_m", i), int'(err_m), int'(tab[i].em));
            chk($sformatf("v%0d_err_o", i), int'(err_o), int'(tab[i].eo));
            chk($sformatf("v%0d_act_m", i), int'(act_m), int'(tab[i].am));
            chk($sformatf("v%0d_act_o", i), int'(act_o), int'(tab[i].ao));
            chk($sformatf("v%0d_rdy0", i), int'(rdy_m), 0);
            tick();
            chk($sformatf("v%0d_rdy1", i), int'(rdy_m), 1);
            chk($sformatf("v%0d_errpulse", i), int'(err_m | err_o), 0);
            chk($sformatf("v%0d_sel_m", i), int'(sel_m), int'(|tab[i].am));
            chk($sformatf("v%0d_sel_o", i), int'(sel_o), int'(|tab[i].ao));
        end

        // back-to-back valid
        voice = 2'd2; on = 1'b1; semi = 4'd0; oct = 2'd0;
        valid = 1'b1;
        r0 = int'(rdy_m);
        tick();
        r1 = int'(rdy_m);
        e = int'(err_m | err_o);
        tick();
        r2 = int'(rdy_m);
        e |= int'(err_m | err_o);
        tick();
        valid = 1'b0;
        e |= int'(err_m | err_o);
        acc = r0 + r1 + r2;
        chk("hs_r0", r0, 1);
        chk("hs_r1", r1, 0);
        chk("hs_r2", r2, 1);
        chk("hs_accepts", acc, 2);
        chk("hs_err", e, 0);
        chk("hs_act", int'(act_m[2] & act_o[2]), 1);
        send(2'd2, 1'b0, 4'd0, 2'd0);
        tick();

        // single tone periods on the OR instance
        send(2'd0, 1'b1, 4'd9, 2'd0);
        wait_spk(1'b1, 1'b1, 10000, n);
        chk("a3_first_rise", n, 2273);
        wait_spk(1'b1, 1'b0, 10000, n);
        chk("a3_high", n, 2272);
        wait_spk(1'b1, 1'b1, 10000, n);
        chk("a3_low", n, 2272);
        send(2'd0, 1'b1, 4'd9, 2'd1);
        wait_spk(1'b1, 1'b1, 10000, n);
        chk("a3o1_first_rise", n, 1137);
        wait_spk(1'b1, 1'b0, 10000, n);
        chk("a3o1_high", n, 1136);
        send(2'd0, 1'b1, 4'd0, 2'd0);
        wait_spk(1'b1, 1'b1, 10000, n);
        chk("c3_first_rise", n, 3823);

        // pause 1000 cycles mid-period
        send(2'd0, 1'b1, 4'd11, 2'd3);
        repeat (100) tick();
        pause = 1'b1;
        repeat (1000) tick();
        pause = 1'b0;
        wait_spk(1'b1, 1'b1, 5000, n);
        chk("pause_rise", 1100 + n, 1254);

        // retrigger with counter at half-1
        send(2'd0, 1'b1, 4'd11, 2'd3);
        repeat (252) tick();
        send(2'd0, 1'b1, 4'd11, 2'd3);
        wait_spk(1'b1, 1'b1, 5000, n);
        chk("retrig_rise", n, 254);

        // PWM mixing: two voices
        send(2'd0, 1'b0, 4'd0, 2'd0);
        send(2'd0, 1'b1, 4'd11, 2'd3);
        send(2'd1, 1'b1, 4'd11, 2'd3);
        repeat (298) tick();
        ones(8, nm, no);
        chk("mix2_duty", nm, 4);
        chk("or2_high", no, 8);

        // all four voices
        send(2'd0, 1'b1, 4'd11, 2'd3);
        send(2'd1, 1'b1, 4'd11, 2'd3);
        send(2'd2, 1'b1, 4'd11, 2'd3);
        send(2'd3, 1'b1, 4'd11, 2'd3);
        repeat (294) tick();
        ones(8, nm, no);
        chk("mix4_duty", nm, 8);
        chk("or4_high", no, 8);
        repeat (292) tick();
        ones(8, nm, no);
        chk("mix4_low", nm, 0);
        chk("or4_low", no, 0);

        // reset mid-note
        repeat (192) tick();
        chk("pre_rst_spk", int'(spk_m), 1);
        rst = 1'b1;
        #1;
        chk("arst_spk", int'(spk_m | spk_o), 0);
        chk("arst_act", int'(act_m) | int'(act_o), 0);
        chk("arst_sel", int'(sel_m | sel_o), 0);
        chk("arst_rdy", int'(rdy_m & rdy_o), 1);
        tick();
        rst = 1'b0;
        noise = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            noise |= int'(spk_m | spk_o | sel_m | sel_o);
            noise |= int'(|act_m) | int'(|act_o);
        end
        chk("post_rst_silent", noise, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
